// File: rtl/iob_cache_axi_read_responder.sv
// AXI4 read-channel responder backed by a 1-cycle-latency synchronous RAM.
// Accepts one AR burst at a time (IDLE/BURST) and streams R beats through a
// 2-entry buffer. A RAM word still in flight is presented straight to R
// (bypass), so a burst runs at 1 beat/cycle when rready stays high.
// Optional build macro IOB_CACHE_AXI_RSP_RANGE_CHK_EN: bursts that fall
// outside MEM_DEPTH words return DECERR beats and never touch the RAM.
module iob_cache_axi_read_responder #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int MEM_DEPTH  = 2**16,
    localparam int NBYTES_W   = $clog2(AXI_DATA_W/8),
    localparam int MEM_ADDR_W = AXI_ADDR_W - NBYTES_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [AXI_ID_W-1:0]   axi_arid_i,
    input  logic [AXI_ADDR_W-1:0] axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]  axi_arlen_i,
    input  logic [2:0]            axi_arsize_i,
    input  logic [1:0]            axi_arburst_i,
    input  logic                  axi_arvalid_i,
    output logic                  axi_arready_o,
    output logic [AXI_ID_W-1:0]   axi_rid_o,
    output logic [AXI_DATA_W-1:0] axi_rdata_o,
    output logic [1:0]            axi_rresp_o,
    output logic                  axi_rlast_o,
    output logic                  axi_rvalid_o,
    input  logic                  axi_rready_i,
    output logic                  mem_en_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    input  logic [AXI_DATA_W-1:0] mem_rdata_i
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } beat_t;

    state_t                state_q;
    logic                  arready_q;
    logic [AXI_ID_W-1:0]   id_q;
    logic [MEM_ADDR_W-1:0] addr_q;
    logic [MEM_ADDR_W-1:0] mask_q;      // bits of the address that advance
    logic [AXI_LEN_W:0]    left_q;      // beats still to be issued to RAM
    logic                  pend_q;      // RAM read in flight, data on mem_rdata_i
    logic                  pend_last_q;
    logic                  err_q;

    beat_t                 fifo_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            cnt_q;

    logic [MEM_ADDR_W-1:0] ar_word, ar_mask, addr_nxt;
    logic                  ar_hs, issue, fifo_vld, rvalid, pop, fifo_pop, push, done;
    beat_t                 pend_beat, head;

    assign ar_word = axi_araddr_i[AXI_ADDR_W-1:NBYTES_W];
    assign ar_hs   = (state_q == IDLE) & arready_q & axi_arvalid_i;

    // Address-advance mask: FIXED holds, valid WRAP cycles the low bits,
    // everything else (INCR, 2'b11, odd WRAP lengths) increments fully.
    always_comb begin
        ar_mask = '1;
        if (axi_arburst_i == 2'b00) begin
            ar_mask = '0;
        end else if (axi_arburst_i == 2'b10 &&
                     (axi_arlen_i == AXI_LEN_W'(1) || axi_arlen_i == AXI_LEN_W'(3) ||
                      axi_arlen_i == AXI_LEN_W'(7) || axi_arlen_i == AXI_LEN_W'(15))) begin
            ar_mask = MEM_ADDR_W'(axi_arlen_i);
        end
    end

    assign addr_nxt = (addr_q & ~mask_q) | ((addr_q + MEM_ADDR_W'(1)) & mask_q);

    // Issue only while buffer + in-flight leaves room for the returning word.
    assign issue = (state_q == BURST) && (left_q != '0) &&
                   ((cnt_q + {1'b0, pend_q}) < 2'd2);

    assign pend_beat.data = err_q ? '0 : mem_rdata_i;
    assign pend_beat.resp = err_q ? 2'b11 : 2'b00;
    assign pend_beat.last = pend_last_q;

    assign fifo_vld = (cnt_q != 2'd0);
    assign rvalid   = fifo_vld | pend_q;
    assign head     = fifo_vld ? fifo_q[rd_ptr_q] : pend_beat;
    assign pop      = rvalid & axi_rready_i;
    assign fifo_pop = pop & fifo_vld;
    // The in-flight word is buffered unless it leaves via the bypass now.
    assign push     = pend_q & ~(pop & ~fifo_vld);
    assign done     = pop & head.last;

    assign axi_arready_o = arready_q;
    assign axi_rid_o     = id_q;
    assign axi_rvalid_o  = rvalid;
    assign axi_rdata_o   = rvalid ? head.data : '0;
    assign axi_rresp_o   = rvalid ? head.resp : 2'b00;
    assign axi_rlast_o   = rvalid & head.last;
    assign mem_en_o      = issue & ~err_q;
    assign mem_addr_o    = addr_q;

    // Burst control: AR acceptance, address walk, RAM read tracking.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            arready_q   <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            left_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            pend_q      <= issue;
            pend_last_q <= issue && (left_q == (AXI_LEN_W+1)'(1));
            case (state_q)
                IDLE: begin
                    if (ar_hs) begin
                        state_q   <= BURST;
                        arready_q <= 1'b0;
                        id_q      <= axi_arid_i;
                        addr_q    <= ar_word;
                        mask_q    <= ar_mask;
                        left_q    <= {1'b0, axi_arlen_i} + (AXI_LEN_W+1)'(1);
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                BURST: begin
                    if (issue) begin
                        addr_q <= addr_nxt;
                        left_q <= left_q - (AXI_LEN_W+1)'(1);
                    end
                    if (done) begin
                        state_q   <= IDLE;
                        arready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Two-entry beat buffer; push and pop together leave occupancy unchanged.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= pend_beat;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (fifo_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, fifo_pop};
        end
    end

`ifdef IOB_CACHE_AXI_RSP_RANGE_CHK_EN
    logic [MEM_ADDR_W:0] ar_end;
    logic                ar_flag;

    assign ar_end  = {1'b0, ar_word} + (MEM_ADDR_W+1)'(axi_arlen_i);
    assign ar_flag = (64'(ar_word) >= 64'(MEM_DEPTH)) ||
                     ((ar_mask == '1) && (64'(ar_end) >= 64'(MEM_DEPTH)));

    // Out-of-range flag is captured once per burst at AR acceptance.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (ar_hs) begin
            err_q <= ar_flag;
        end
    end
`else
    assign err_q = 1'b0;
`endif

    // Beat size is always full width; byte offset bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, axi_arsize_i, axi_araddr_i, MEM_DEPTH[0]};

endmodule

// File: tb/tb_iob_cache_axi_read_responder.sv
// Directed bench for iob_cache_axi_read_responder: a table of AR bursts with
// hand-computed RAM word sequences plus hand sequences for back-to-back
// single beats and reset in mid-burst. RAM model returns 0xD0000000|word.
module tb_iob_cache_axi_read_responder;
    localparam int ID_W = 1, ADDR_W = 24, DATA_W = 32, LEN_W = 8, DEPTH = 16, MA_W = 22;
`ifdef IOB_CACHE_AXI_RSP_RANGE_CHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid, arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid, rready;
    logic              mem_en;
    logic [MA_W-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    iob_cache_axi_read_responder #(
        .AXI_ID_W(ID_W), .AXI_ADDR_W(ADDR_W), .AXI_DATA_W(DATA_W),
        .AXI_LEN_W(LEN_W), .MEM_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .reset_i(rst),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen),
        .axi_arsize_i(arsize), .axi_arburst_i(arburst), .axi_arvalid_i(arvalid),
        .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp),
        .axi_rlast_o(rlast), .axi_rvalid_o(rvalid), .axi_rready_i(rready),
        .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
    );

    // 1-cycle-latency RAM with a recognisable per-word pattern
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= 32'hD000_0000 | 32'(mem_addr);
    end

    typedef struct {
        string           name;
        logic [ID_W-1:0] id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0] len;
        logic [1:0]      burst;
        logic [15:0]     rdy;     // rready per cycle after AR, bit n-1 for cycle n
        logic [MA_W-1:0] w [4];   // expected RAM word per beat
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(string n, logic [ID_W-1:0] id, logic [ADDR_W-1:0] a,
                                logic [LEN_W-1:0] l, logic [1:0] b, logic [15:0] r,
                                logic [MA_W-1:0] w0, logic [MA_W-1:0] w1,
                                logic [MA_W-1:0] w2, logic [MA_W-1:0] w3);
        vec_t t;
        t.name = n; t.id = id; t.addr = a; t.len = l; t.burst = b; t.rdy = r;
        t.w[0] = w0; t.w[1] = w1; t.w[2] = w2; t.w[3] = w3;
        return t;
    endfunction

    function automatic bit flagged(vec_t t);
        int s;
        s = int'(t.addr[ADDR_W-1:2]);
        if (!RCHK) return 1'b0;
        if (s >= DEPTH) return 1'b1;
        if (t.burst != 2'b00 && !(t.burst == 2'b10 && t.len inside {8'd1, 8'd3, 8'd7, 8'd15})
            && (s + int'(t.len)) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t t);
        bit   f;
        int   nb, issued, got, n, first_v, last_n, guard;
        bit   ar_bad, occ_bad, hold_bad, en_bad, extra;
        bit   pv, pr;
        logic [DATA_W-1:0] pd;
        logic pl;
        f = flagged(t); nb = int'(t.len) + 1;
        issued = 0; got = 0; n = 0; first_v = -1; last_n = -1; guard = 0;
        ar_bad = 0; occ_bad = 0; hold_bad = 0; en_bad = 0; extra = 0; pv = 0; pr = 0;
        pd = '0; pl = 1'b0;
        @(negedge clk);
        while (!arready && guard < 20) begin @(negedge clk); guard++; end
        chk({t.name, "_arready_idle"}, 64'(arready), 64'd1);
        arid = t.id; araddr = t.addr; arlen = t.len; arburst = t.burst; arvalid = 1'b1;
        @(posedge clk);
        while (got < nb && n < 100) begin
            @(negedge clk);
            n++;
            arvalid = 1'b0;
            rready  = t.rdy[(n-1) % 16];
            if (arready) ar_bad = 1'b1;
            if (mem_en) begin
                if (f) en_bad = 1'b1;
                else if (issued >= nb) extra = 1'b1;
                else chk({t.name, "_mem_addr"}, 64'(mem_addr), 64'(t.w[issued]));
                issued++;
                if (issued - got > 2) occ_bad = 1'b1;
            end
            if (pv && !pr && !(rvalid && rdata == pd && rlast == pl)) hold_bad = 1'b1;
            if (rvalid && first_v < 0) first_v = n;
            if (rvalid && rready) begin
                chk({t.name, "_rdata"}, 64'(rdata), f ? 64'd0 : 64'(32'hD000_0000 | 32'(t.w[got])));
                chk({t.name, "_rresp"}, 64'(rresp), f ? 64'd3 : 64'd0);
                chk({t.name, "_rlast"}, 64'(rlast), 64'(got == nb - 1));
                chk({t.name, "_rid"}, 64'(rid), 64'(t.id));
                got++;
                if (got == nb) last_n = n;
            end
            pv = rvalid; pr = rready; pd = rdata; pl = rlast;
        end
        chk({t.name, "_beats"}, 64'(got), 64'(nb));
        if (f) chk({t.name, "_mem_en_seen"}, 64'(en_bad), 64'd0);
        else   chk({t.name, "_issues"}, 64'(issued), 64'(nb));
        chk({t.name, "_extra_issue"}, 64'(extra), 64'd0);
        chk({t.name, "_arready_in_burst"}, 64'(ar_bad), 64'd0);
        chk({t.name, "_occupancy"}, 64'(occ_bad), 64'd0);
        chk({t.name, "_hold"}, 64'(hold_bad), 64'd0);
        if (t.rdy == 16'hFFFF) begin
            chk({t.name, "_first_rvalid_cycle"}, 64'(first_v), 64'd2);
            chk({t.name, "_last_beat_cycle"}, 64'(last_n), 64'(nb + 1));
        end
        rready = 1'b1;
        @(negedge clk);
        chk({t.name, "_arready_after"}, 64'(arready), 64'd1);
        chk({t.name, "_rvalid_after"}, 64'(rvalid), 64'd0);
        chk({t.name, "_mem_en_after"}, 64'(mem_en), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b0; rready = 1'b1;

        vecs[0] = mk("incr4",      1'b1, 24'h000100, 8'd3, 2'b01, 16'hFFFF, 22'h40, 22'h41, 22'h42, 22'h43);
        vecs[1] = mk("incr4_bp",   1'b0, 24'h000100, 8'd3, 2'b01, 16'h9999, 22'h40, 22'h41, 22'h42, 22'h43);
        vecs[2] = mk("fixed3",     1'b1, 24'h000020, 8'd2, 2'b00, 16'hFFFF, 22'h08, 22'h08, 22'h08, 22'h0);
        vecs[3] = mk("wrap4",      1'b0, 24'h000018, 8'd3, 2'b10, 16'hFFFF, 22'h06, 22'h07, 22'h04, 22'h05);
        vecs[4] = mk("wrap3_incr", 1'b1, 24'h000014, 8'd2, 2'b10, 16'hFFFF, 22'h05, 22'h06, 22'h07, 22'h0);
        vecs[5] = mk("burst11",    1'b0, 24'h000040, 8'd1, 2'b11, 16'h5555, 22'h10, 22'h11, 22'h0,  22'h0);
        vecs[6] = mk("single",     1'b1, 24'h0003FC, 8'd0, 2'b01, 16'hFFFF, 22'hFF, 22'h0,  22'h0,  22'h0);
        vecs[7] = mk("addr_wrap",  1'b0, 24'hFFFFF8, 8'd2, 2'b01, 16'hFFFF, 22'h3FFFFE, 22'h3FFFFF, 22'h0, 22'h0);
        vecs[8] = mk("range14",    1'b1, 24'h000038, 8'd3, 2'b01, 16'hFFFF, 22'h0E, 22'h0F, 22'h10, 22'h11);

        // reset state
        #1;
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        chk("rst_rid", 64'(rid), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        repeat (2) @(negedge clk);
        chk("rst_hold_arready", 64'(arready), 64'd0);
        rst = 1'b0;
        #1 chk("rst_release_arready", 64'(arready), 64'd0);
        @(negedge clk);
        chk("rst_first_edge_arready", 64'(arready), 64'd1);

        for (int i = 0; i < 9; i++) run_burst(vecs[i]);

        // back-to-back single-beat ARs with arvalid held high
        @(negedge clk);
        araddr = 24'h000014; arlen = 8'd0; arburst = 2'b01; arid = 1'b1; arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_arready_c1", 64'(arready), 64'd0);
        chk("b2b_mem_en_c1", 64'(mem_en), 64'd1);
        chk("b2b_mem_addr_c1", 64'(mem_addr), 64'h05);
        @(negedge clk);
        chk("b2b_rvalid_c2", 64'(rvalid), 64'd1);
        chk("b2b_rlast_c2", 64'(rlast), 64'd1);
        chk("b2b_rdata_c2", 64'(rdata), 64'hD000_0005);
        chk("b2b_arready_c2", 64'(arready), 64'd0);
        @(negedge clk);
        chk("b2b_arready_c3", 64'(arready), 64'd1);
        chk("b2b_rvalid_c3", 64'(rvalid), 64'd0);
        @(negedge clk);
        arvalid = 1'b0;
        chk("b2b_arready_c4", 64'(arready), 64'd0);
        chk("b2b_mem_en_c4", 64'(mem_en), 64'd1);
        @(negedge clk);
        chk("b2b_rvalid_c5", 64'(rvalid), 64'd1);
        chk("b2b_rdata_c5", 64'(rdata), 64'hD000_0005);
        chk("b2b_rlast_c5", 64'(rlast), 64'd1);
        @(negedge clk);
        chk("b2b_arready_c6", 64'(arready), 64'd1);

        // reset during beat 2 of an 8-beat burst
        @(negedge clk);
        araddr = 24'h000020; arlen = 8'd7; arburst = 2'b01; arid = 1'b0; arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk); arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rvalid_beat2", 64'(rvalid), 64'd1);
        chk("mid_rdata_beat2", 64'(rdata), 64'hD000_0009);
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
        chk("mid_rst_mem_en", 64'(mem_en), 64'd0);
        chk("mid_rst_arready", 64'(arready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_release_arready", 64'(arready), 64'd0);
        @(negedge clk);
        chk("mid_first_edge_arready", 64'(arready), 64'd1);
        chk("mid_idle_rvalid", 64'(rvalid), 64'd0);
        run_burst(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iob_cache_axi_read_responder.md
Name: iob_cache_axi_read_responder

Overview:
AXI4 read-channel slave (responder) serving AR/R bursts from a single-port synchronous RAM with 1-cycle read latency. It is the memory-side counterpart of the cache line-refill read master. It is used as a backing-memory model in cache testbenches and as a lightweight on-chip AXI read target. A 2-entry output buffer sustains 1 beat/cycle under `rready` backpressure without losing RAM data.

Parameters:
- AXI_ID_W, 1: width of `arid`/`rid`.
- AXI_ADDR_W, 24: byte address width.
- AXI_DATA_W, 32: data width; power of 2, ≥8.
- AXI_LEN_W, 8: `arlen` width.
- MEM_DEPTH, 2**16: RAM words; used only by the optional range check.
- NBYTES_W (derived), $clog2(AXI_DATA_W/8): byte-offset bits.
- MEM_ADDR_W (derived), AXI_ADDR_W-NBYTES_W: word address width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  async reset, active-high
- axi_arid_i  in  AXI_ID_W  burst ID
- axi_araddr_i  in  AXI_ADDR_W  start byte address
- axi_arlen_i  in  AXI_LEN_W  beats-1
- axi_arsize_i  in  3  beat size; ignored, always full width
- axi_arburst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR
- axi_arvalid_i  in  1  AR valid
- axi_arready_o  out  1  AR ready
- axi_rid_o  out  AXI_ID_W  latched ID
- axi_rdata_o  out  AXI_DATA_W  read data
- axi_rresp_o  out  2  response
- axi_rlast_o  out  1  last beat
- axi_rvalid_o  out  1  R valid
- axi_rready_i  in  1  R ready
- mem_en_o  out  1  RAM read enable
- mem_addr_o  out  MEM_ADDR_W  RAM word address
- mem_rdata_i  in  AXI_DATA_W  RAM data, valid 1 cycle after `mem_en_o`

Behaviour:
- Reset: reset_i (asynchronous, active-high) with clock clk_i.
  - On reset, all outputs are 0, the state is IDLE and the buffer is empty.
  - `arready_o` rises on the first clk_i edge after reset_i deasserts.
- States IDLE, BURST.
- IDLE:
  - `arready_o` = 1.
  - On `arvalid_i & arready_o`, latch `arid`, word address = `araddr[AXI_ADDR_W-1:NBYTES_W]`, `issue_cnt = arlen`, `beat_cnt = arlen` and the burst type.
  - Go to BURST; `arready_o` drops the same edge.
- BURST:
  - `arready_o` = 0.
  - Issue rule: assert `mem_en_o` while beats remain to issue and (buffer occupancy + reads in flight) < 2.
    - Each issue advances the address.
    - FIXED: address unchanged.
    - INCR: +1, wraps modulo 2**MEM_ADDR_W.
    - WRAP: low `log2(arlen+1)` bits increment modulo `arlen+1`, upper bits held; `arlen` is 1, 3, 7 or 15, other values behave as INCR.
  - The cycle after `mem_en_o`, `mem_rdata_i` is written into the 2-entry FIFO, tagged with last = (issued beat was final) and rresp = 00.
  - R side: `rvalid_o` = FIFO not empty; `rdata`/`rlast`/`rresp` come from the FIFO head and `rid_o` from the latched ID.
  - Outputs hold stable while `rvalid & !rready`.
  - On the handshake with `rlast` = 1: go to IDLE; `arready_o` = 1 next cycle.
- Latency: AR handshake at edge k → `mem_en_o` high in cycle k+1 → `rvalid_o` high in cycle k+2.
  - Continuous `rready` = 1 gives 1 beat/cycle, so a burst of N beats completes at edge k+N+1.
- Backpressure: `rready` low keeps at most 2 beats buffered and stalls issue; no data is dropped or duplicated.
- Simultaneous FIFO push and pop in the same cycle: occupancy is unchanged.
- `arlen` = 0: a single beat with `rlast` = 1.
- New AR while in BURST is not accepted; `arvalid` waits.
- Reset mid-burst: in-flight reads and buffered beats are discarded, `rvalid_o`/`mem_en_o` = 0 immediately, state returns to IDLE.

Optional Feature:
IOB_CACHE_AXI_RSP_RANGE_CHK_EN
- Defined:
  - At AR accept, a start word address ≥ MEM_DEPTH, or INCR end address (start+arlen) ≥ MEM_DEPTH, flags the burst.
  - A flagged burst returns arlen+1 beats with rresp = 2'b11 (DECERR), rdata = 0, correct `rlast`, and never asserts `mem_en_o`.
  - Beat timing is unchanged.
- Undefined: no check; addresses wrap modulo 2**MEM_ADDR_W and rresp is always 2'b00.

Test Plan:
- Reset, then AR INCR addr 0x100, arlen = 3, rready = 1 → `mem_addr` 0x40..0x43 on consecutive cycles; 4 beats, `rvalid` from cycle k+2, `rlast` only on beat 4, rresp = 00, rid = arid.
- Same burst, rready toggling 1, 0, 0, 1, … → data order 0x40..0x43 intact; no beat lost; occupancy never exceeds 2; `mem_en` stalls when full.
- FIXED arlen = 2 at 0x20 → `mem_addr` 0x08 three times; WRAP arlen = 3 at word 0x06 → 0x06, 0x07, 0x04, 0x05.
- arlen = 0 back-to-back ARs → `arready` low for the burst duration, high 1 cycle after `rlast` handshake; second burst served correctly.
- Assert reset_i during beat 2 of an 8-beat burst → `rvalid`/`mem_en` 0 immediately; after release, a fresh AR returns correct data.
- With IOB_CACHE_AXI_RSP_RANGE_CHK_EN, MEM_DEPTH = 16, AR word 14 INCR arlen = 3 → 4 beats rresp = 11, rdata = 0, `mem_en` never high; without it → words 14, 15, 16, 17 read with rresp = 00.
